// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types for the SPI bus arbiter.
//   state_t   : sequencer states (IDLE, START, WAIT, DONE)
//   idx_width : bit width of a requester index for n requesters
package spi_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Combinational round-robin picker.  Searches upward from pointer+1,
// wrapping modulo NUM_REQ, and returns the first requester found.
// Ports:
//   req     in  NUM_REQ  request vector
//   pointer in  IDX_W    index of the most recent grant
//   any     out 1        at least one request pending
//   grant   out IDX_W    index of the winning requester (0 when none)
module rr_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic               any,
    output logic [IDX_W-1:0]   grant
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest candidate towards the nearest so the last hit,
    // which is the nearest one after the pointer, is the one that sticks.
    always_comb begin
        any   = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(pointer) + k) % NUM_REQ);
            if (req[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master among NUM_REQ requesters, one transaction per grant,
// round-robin.  Issues the start pulse, waits for done and returns the
// received word with a one-cycle one-hot ack to the winner.
// Optional feature macro: SPI_BUS_ARBITER_TIMEOUT_EN (WAIT watchdog, err out).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req/req_ss/req_data per-requester request level, slave index, tx word
//   ack/rsp_data/err    one-hot completion pulse, rx word, timeout flag
//   spi_start/ss/tx     start pulse and latched transaction to the master
//   spi_busy/done/rx    master status and received word
//
// state | meaning
// IDLE  | arbitrate when a request is pending and the master is free
// START | one-cycle start pulse to the master
// WAIT  | waiting for spi_done (or the watchdog)
// DONE  | ack the granted requester, advance the round-robin pointer
module spi_bus_arbiter
    import spi_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int word_width    = 8,
    parameter int SS_width      = 1,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*SS_width-1:0]    req_ss,
    input  logic [NUM_REQ*word_width-1:0]  req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic [word_width-1:0]          rsp_data,
    output logic                           err,
    output logic                           spi_start,
    output logic [SS_width-1:0]            spi_ss,
    output logic [word_width-1:0]          spi_tx,
    input  logic                           spi_busy,
    input  logic                           spi_done,
    input  logic [word_width-1:0]          spi_rx
);

    localparam int IW = idx_width(NUM_REQ);

    state_t            state, state_next;
    logic [IW-1:0]     pointer, grant_idx, pick_idx;
    logic              pick_any, grant_now, to_hit;
    logic [SS_width-1:0]   ss_slice [NUM_REQ];
    logic [word_width-1:0] tx_slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign ss_slice[i] = req_ss[i*SS_width +: SS_width];
        assign tx_slice[i] = req_data[i*word_width +: word_width];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IW)) u_rr (
        .req     (req),
        .pointer (pointer),
        .any     (pick_any),
        .grant   (pick_idx)
    );

    assign grant_now = (state == IDLE) && pick_any && !spi_busy;

`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
    // Down-counter loaded while in START; terminal count at zero in WAIT
    // lands DONE 2**TIMEOUT_WIDTH cycles after the start pulse.
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LOAD = TIMEOUT_WIDTH'(2**TIMEOUT_WIDTH - 2);
    logic [TIMEOUT_WIDTH-1:0] to_cnt;
    logic                     timed_out;

    assign to_hit = (state == WAIT) && !spi_done && (to_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt    <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state == START) begin
                to_cnt    <= TO_LOAD;
                timed_out <= 1'b0;
            end else if (state == WAIT && to_cnt != '0) begin
                to_cnt <= to_cnt - TIMEOUT_WIDTH'(1);
            end
            if (to_hit)
                timed_out <= 1'b1;
        end
    end
`else
    logic unused_timeout_width;
    assign to_hit = 1'b0;
    assign unused_timeout_width = (TIMEOUT_WIDTH > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (grant_now) state_next = START;
            START: state_next = WAIT;
            WAIT:  if (spi_done || to_hit) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        spi_start = (state == START);
        ack       = '0;
        if (state == DONE)
            ack[grant_idx] = 1'b1;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
        err = (state == DONE) && timed_out;
`else
        err = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pointer   <= IW'(NUM_REQ - 1);
            grant_idx <= '0;
            spi_ss    <= '0;
            spi_tx    <= '0;
            rsp_data  <= '0;
        end else begin
            if (grant_now) begin
                grant_idx <= pick_idx;
                spi_ss    <= ss_slice[pick_idx];
                spi_tx    <= tx_slice[pick_idx];
            end
            if (state == WAIT && spi_done)
                rsp_data <= spi_rx;
            else if (to_hit)
                rsp_data <= '0;
            if (state == DONE)
                pointer <= grant_idx;
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  req_ss;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  rsp_data;
    logic        err;
    logic        spi_start;
    logic [0:0]  spi_ss;
    logic [7:0]  spi_tx;
    logic        spi_busy;
    logic        spi_done;
    logic [7:0]  spi_rx;

    int checks = 0;
    int errors = 0;

    spi_bus_arbiter #(
        .NUM_REQ(4), .word_width(8), .SS_width(1), .TIMEOUT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_ss(req_ss), .req_data(req_data),
        .ack(ack), .rsp_data(rsp_data), .err(err),
        .spi_start(spi_start), .spi_ss(spi_ss), .spi_tx(spi_tx),
        .spi_busy(spi_busy), .spi_done(spi_done), .spi_rx(spi_rx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the IDLE cycle whose closing edge grants g.
    task automatic run_txn(input int g, input logic [3:0] req_mid, input logic [7:0] rx);
        tick();
        chk("txn_start", 32'(spi_start), 32'd1);
        chk("txn_tx", 32'(spi_tx), 32'(req_data[g*8 +: 8]));
        chk("txn_ss", 32'(spi_ss), 32'(req_ss[g]));
        req = req_mid;
        tick();
        chk("txn_wait_ack", 32'(ack), 32'd0);
        spi_done = 1'b1;
        spi_rx   = rx;
        tick();
        chk("txn_ack", 32'(ack), 32'(4'b0001 << g));
        chk("txn_rsp", 32'(rsp_data), 32'(rx));
        chk("txn_err", 32'(err), 32'd0);
        spi_done = 1'b0;
        tick();
    endtask

    initial begin
        bit seen_ack, seen_err;
        rst = 1'b1; req = '0; req_ss = '0; req_data = '0;
        spi_busy = 1'b0; spi_done = 1'b0; spi_rx = '0;
        tick(); tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_start", 32'(spi_start), 32'd0);
        chk("rst_ss", 32'(spi_ss), 32'd0);
        chk("rst_tx", 32'(spi_tx), 32'd0);
        chk("rst_rsp", 32'(rsp_data), 32'd0);

        // Single requester, spi_done at cycle 5
        rst = 1'b0;
        req = 4'b0100; req_ss = 4'b0100; req_data = 32'h00A5_0000;
        tick();
        chk("single_start_c1", 32'(spi_start), 32'd1);
        chk("single_ss", 32'(spi_ss), 32'd1);
        chk("single_tx", 32'(spi_tx), 32'hA5);
        tick();
        chk("single_start_c2", 32'(spi_start), 32'd0);
        tick(); tick(); tick();
        spi_done = 1'b1; spi_rx = 8'h3C;
        tick();
        chk("single_ack_c6", 32'(ack), 32'b0100);
        chk("single_rsp_c6", 32'(rsp_data), 32'h3C);
        chk("single_err", 32'(err), 32'd0);
        spi_done = 1'b0; req = 4'b0000;
        tick();
        chk("single_ack_c7", 32'(ack), 32'd0);
        chk("single_rsp_hold", 32'(rsp_data), 32'h3C);
        spi_done = 1'b1; spi_rx = 8'hFF;
        tick();
        spi_done = 1'b0;
        chk("stray_done_rsp", 32'(rsp_data), 32'h3C);
        chk("stray_done_ack", 32'(ack), 32'd0);
        chk("stray_done_idle", 32'(spi_start), 32'd0);

        // All requesting after reset: 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111; req_ss = 4'b1010; req_data = 32'h4433_2211;
        run_txn(0, 4'b1111, 8'hC0);
        run_txn(1, 4'b1111, 8'hC1);
        run_txn(2, 4'b1111, 8'hC2);
        run_txn(3, 4'b1111, 8'hC3);
        run_txn(0, 4'b1111, 8'hC4);

        // Rotation: req0 held, req2 raised mid-transaction
        req = 4'b0001;
        run_txn(0, 4'b0101, 8'h70);
        run_txn(2, 4'b0101, 8'h72);
        run_txn(0, 4'b0000, 8'h71);

        // Busy hold
        spi_busy = 1'b1; req = 4'b0001;
        tick(); chk("busy_hold_1", 32'(spi_start), 32'd0);
        tick(); chk("busy_hold_2", 32'(spi_start), 32'd0);
        tick(); chk("busy_hold_3", 32'(spi_start), 32'd0);
        spi_busy = 1'b0;
        tick();
        chk("busy_release_start", 32'(spi_start), 32'd1);
        chk("busy_release_tx", 32'(spi_tx), 32'h11);
        req = 4'b0000;
        tick();
        spi_done = 1'b1; spi_rx = 8'h99;
        tick();
        chk("busy_ack", 32'(ack), 32'b0001);
        chk("busy_rsp", 32'(rsp_data), 32'h99);
        spi_done = 1'b0;
        tick();

        // Reset mid-transaction (pointer=0, so requester 1 wins first)
        req = 4'b0011;
        tick();
        chk("mid_start", 32'(spi_start), 32'd1);
        chk("mid_tx", 32'(spi_tx), 32'h22);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_rsp", 32'(rsp_data), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_start", 32'(spi_start), 32'd1);
        chk("post_rst_tx_req0", 32'(spi_tx), 32'h11);
        spi_done = 1'b1; spi_rx = 8'hEE;
        tick();
        chk("post_rst_no_ack", 32'(ack), 32'd0);
        chk("post_rst_rsp", 32'(rsp_data), 32'd0);
        spi_done = 1'b0; req = 4'b0000;
        tick();
        chk("post_rst_wait", 32'(ack), 32'd0);
        spi_done = 1'b1; spi_rx = 8'h5A;
        tick();
        chk("post_rst_ack", 32'(ack), 32'b0001);
        chk("post_rst_rsp2", 32'(rsp_data), 32'h5A);
        spi_done = 1'b0;
        tick();

        // No spi_done: watchdog (macro on) or indefinite wait
        req = 4'b0100;
        tick();
        chk("to_start", 32'(spi_start), 32'd1);
        req = 4'b0000;
        seen_ack = 1'b0; seen_err = 1'b0;
`ifdef SPI_BUS_ARBITER_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            if (ack != 4'b0000) seen_ack = 1'b1;
            if (err) seen_err = 1'b1;
        end
        chk("to_early_ack", 32'(seen_ack), 32'd0);
        chk("to_early_err", 32'(seen_err), 32'd0);
        tick();
        chk("to_ack", 32'(ack), 32'b0100);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rsp", 32'(rsp_data), 32'd0);
        tick();
        chk("to_err_pulse", 32'(err), 32'd0);
        chk("to_ack_pulse", 32'(ack), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ack != 4'b0000) seen_ack = 1'b1;
            if (err) seen_err = 1'b1;
        end
        chk("nodone_no_ack", 32'(seen_ack), 32'd0);
        chk("nodone_no_err", 32'(seen_err), 32'd0);
        chk("nodone_rsp_hold", 32'(rsp_data), 32'h5A);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
